// File: rtl/bp_cce_dir_lru_reader_pkg.sv
// Shared types for the directory LRU reader: coherence state encoding and
// width helpers used by the reader and its LRU extraction sub-module.
package bp_cce_dir_lru_reader_pkg;

    typedef enum logic [2:0] {
        e_COH_I = 3'b000,
        e_COH_S = 3'b001,
        e_COH_E = 3'b010,
        e_COH_F = 3'b011,
        e_COH_M = 3'b110,
        e_COH_O = 3'b111
    } bp_coh_states_e;

    localparam int coh_state_width_gp = $bits(bp_coh_states_e);

    // Width of an index into x items; never returns 0 so ports stay legal.
    function automatic int safe_clog2(input int x);
        return (x > 1) ? $clog2(x) : 1;
    endfunction

endpackage

// File: rtl/bp_cce_dir_lru_reader_extract.sv
// Picks the requesting LCE's LRU way out of one directory row. A directory
// entry is {tag, state}; each row holds one tag set of assoc_p entries per LCE.
module bp_cce_dir_lru_extract
    import bp_cce_dir_lru_reader_pkg::*;
#(
    parameter int tag_sets_per_row_p = 2,
    parameter int assoc_p            = 8,
    parameter int tag_width_p        = 10,
    parameter int num_lce_p          = 8,
    parameter int row_num_width_p    = 3,
    parameter int row_width_p        = tag_sets_per_row_p * assoc_p * (tag_width_p + coh_state_width_gp)
) (
    input  logic [row_width_p-1:0]               row_i,
    input  logic [tag_sets_per_row_p-1:0]        row_v_i,
    input  logic [row_num_width_p-1:0]           row_num_i,
    input  logic [safe_clog2(num_lce_p)-1:0]     lce_i,
    input  logic [safe_clog2(assoc_p)-1:0]       lru_way_i,
    output logic                                 lru_v_o,
    output bp_coh_states_e                       lru_coh_state_o,
    output logic [tag_width_p-1:0]               lru_tag_o
);

    localparam int entry_width_lp = tag_width_p + coh_state_width_gp;

    logic [tag_sets_per_row_p-1:0][assoc_p-1:0][entry_width_lp-1:0] entries;
    logic [entry_width_lp-1:0] lru_entry;
    logic                      tag_set_sel;

    assign entries     = row_i;
    assign tag_set_sel = lce_i[0];
    assign lru_entry   = entries[tag_set_sel][lru_way_i];

    // Compare at 32 bits so a small row counter never aliases a large LCE row.
    assign lru_v_o = row_v_i[tag_set_sel] && (32'(row_num_i) == 32'(lce_i >> 1));

    assign lru_coh_state_o = bp_coh_states_e'(lru_entry[coh_state_width_gp-1:0]);
    assign lru_tag_o       = lru_entry[entry_width_lp-1:coh_state_width_gp];

endmodule

// File: rtl/bp_cce_dir_lru_reader.sv
// Walks every directory row of one set with pipelined single-row reads,
// streams each row out and captures the requesting LCE's LRU way.
module bp_cce_dir_lru_reader
    import bp_cce_dir_lru_reader_pkg::*;
#(
    parameter int sets_p             = 64,
    parameter int rows_per_set_p     = 4,
    parameter int tag_sets_per_row_p = 2,
    parameter int num_lce_p          = 8,
    parameter int assoc_p            = 8,
    parameter int tag_width_p        = 10,
    parameter int row_width_p        = tag_sets_per_row_p * assoc_p * (tag_width_p + coh_state_width_gp)
) (
    input  logic                                          clk_i,
    input  logic                                          reset_i,
    input  logic                                          req_v_i,
    output logic                                          req_ready_and_o,
    input  logic [safe_clog2(sets_p)-1:0]                 req_set_i,
    input  logic [safe_clog2(num_lce_p)-1:0]              req_lce_i,
    input  logic [safe_clog2(assoc_p)-1:0]                req_lru_way_i,
    output logic                                          ram_v_o,
    output logic [safe_clog2(sets_p*rows_per_set_p)-1:0]  ram_addr_o,
    input  logic                                          ram_yumi_i,
    input  logic [row_width_p-1:0]                        ram_data_i,
    output logic                                          row_v_o,
    output logic [row_width_p-1:0]                        row_o,
    output logic [safe_clog2(rows_per_set_p)-1:0]         row_num_o,
    output logic                                          row_last_o,
    output logic                                          lru_v_o,
    input  logic                                          lru_yumi_i,
    output bp_coh_states_e                                lru_coh_state_o,
    output logic [tag_width_p-1:0]                        lru_tag_o
);

    localparam int lg_sets_lp    = safe_clog2(sets_p);
    localparam int lg_rows_lp    = safe_clog2(rows_per_set_p);
    localparam int cnt_width_lp  = lg_rows_lp + 1;
    localparam int lg_num_lce_lp = safe_clog2(num_lce_p);
    localparam int lg_assoc_lp   = safe_clog2(assoc_p);
    localparam int addr_width_lp = safe_clog2(sets_p * rows_per_set_p);

    typedef enum logic [1:0] {
        e_ready,
        e_read,
        e_resp
    } state_e;

    state_e                   state_q, state_d;
    logic [lg_sets_lp-1:0]    set_q, set_d;
    logic [lg_num_lce_lp-1:0] lce_q, lce_d;
    logic [lg_assoc_lp-1:0]   way_q, way_d;
    logic [cnt_width_lp-1:0]  rd_cnt_q, rd_cnt_d;
    logic [cnt_width_lp-1:0]  ret_cnt_q, ret_cnt_d;
    logic                     pending_q, pending_d;
    bp_coh_states_e           lru_state_q, lru_state_d;
    logic [tag_width_p-1:0]   lru_tag_q, lru_tag_d;

    logic                          req_ready;
    logic                          rd_active;
    logic                          lru_v;
    logic                          row_last;
    logic [addr_width_lp-1:0]      ram_addr_full;
    logic [tag_sets_per_row_p-1:0] tag_set_v;
    logic                          ex_v;
    bp_coh_states_e                ex_state;
    logic [tag_width_p-1:0]        ex_tag;

    assign row_last = pending_q && (ret_cnt_q == cnt_width_lp'(rows_per_set_p - 1));

    // A tag set is only meaningful if the LCE it belongs to actually exists.
    for (genvar gi = 0; gi < tag_sets_per_row_p; gi++) begin : g_tag_set_v
        assign tag_set_v[gi] = pending_q
            && ((32'(ret_cnt_q) * 32'(tag_sets_per_row_p) + 32'(gi)) < 32'(num_lce_p));
    end

    bp_cce_dir_lru_extract #(
        .tag_sets_per_row_p(tag_sets_per_row_p),
        .assoc_p           (assoc_p),
        .tag_width_p       (tag_width_p),
        .num_lce_p         (num_lce_p),
        .row_num_width_p   (cnt_width_lp),
        .row_width_p       (row_width_p)
    ) u_extract (
        .row_i          (ram_data_i),
        .row_v_i        (tag_set_v),
        .row_num_i      (ret_cnt_q),
        .lce_i          (lce_q),
        .lru_way_i      (way_q),
        .lru_v_o        (ex_v),
        .lru_coh_state_o(ex_state),
        .lru_tag_o      (ex_tag)
    );

    always_comb begin
        state_d     = state_q;
        set_d       = set_q;
        lce_d       = lce_q;
        way_d       = way_q;
        rd_cnt_d    = rd_cnt_q;
        ret_cnt_d   = ret_cnt_q;
        pending_d   = 1'b0;
        lru_state_d = lru_state_q;
        lru_tag_d   = lru_tag_q;
        req_ready   = 1'b0;
        rd_active   = 1'b0;
        lru_v       = 1'b0;

        unique case (state_q)
            e_ready: begin
                req_ready = 1'b1;
                if (req_v_i) begin
                    set_d       = req_set_i;
                    lce_d       = req_lce_i;
                    way_d       = req_lru_way_i;
                    rd_cnt_d    = '0;
                    ret_cnt_d   = '0;
                    lru_state_d = e_COH_I;
                    lru_tag_d   = '0;
                    state_d     = e_read;
                end
            end
            e_read: begin
                rd_active = (rd_cnt_q < cnt_width_lp'(rows_per_set_p));
                if (rd_active && ram_yumi_i) begin
                    rd_cnt_d  = rd_cnt_q + cnt_width_lp'(1);
                    pending_d = 1'b1;
                end
                if (pending_q) begin
                    ret_cnt_d = ret_cnt_q + cnt_width_lp'(1);
                    if (row_last) begin
                        state_d = e_resp;
                    end
                end
                if (ex_v) begin
                    lru_state_d = ex_state;
                    lru_tag_d   = ex_tag;
                end
            end
            e_resp: begin
                lru_v = 1'b1;
                if (lru_yumi_i) begin
                    state_d = e_ready;
                end
            end
            default: state_d = e_ready;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q     <= e_ready;
            set_q       <= '0;
            lce_q       <= '0;
            way_q       <= '0;
            rd_cnt_q    <= '0;
            ret_cnt_q   <= '0;
            pending_q   <= 1'b0;
            lru_state_q <= e_COH_I;
            lru_tag_q   <= '0;
        end else begin
            state_q     <= state_d;
            set_q       <= set_d;
            lce_q       <= lce_d;
            way_q       <= way_d;
            rd_cnt_q    <= rd_cnt_d;
            ret_cnt_q   <= ret_cnt_d;
            pending_q   <= pending_d;
            lru_state_q <= lru_state_d;
            lru_tag_q   <= lru_tag_d;
        end
    end

    assign ram_addr_full = addr_width_lp'(32'(set_q) * 32'(rows_per_set_p) + 32'(rd_cnt_q));

    // Everything is forced quiet while reset is held, so a return already in
    // flight when reset arrives is never presented downstream.
    assign req_ready_and_o = req_ready & ~reset_i;
    assign ram_v_o         = rd_active & ~reset_i;
    assign ram_addr_o      = ram_v_o ? ram_addr_full : '0;
    assign row_v_o         = pending_q & ~reset_i;
    assign row_o           = row_v_o ? ram_data_i : '0;
    assign row_num_o       = row_v_o ? ret_cnt_q[lg_rows_lp-1:0] : '0;
    assign row_last_o      = row_last & ~reset_i;
    assign lru_v_o         = lru_v & ~reset_i;
    assign lru_coh_state_o = lru_state_q;
    assign lru_tag_o       = lru_tag_q;

endmodule

// File: doc/bp_cce_dir_lru_reader.md
# bp_cce_dir_lru_reader

Sequencer that walks every directory RAM row of one set on behalf of a CCE request. It issues pipelined single-row reads and streams each returned row to downstream consumers, such as sharer gathering. It also uses one `bp_cce_dir_lru_extract` instance to capture the coherence state and tag of the requesting LCE's LRU way. The block sits between the CCE directory front end and the directory RAM read port, which it shares with a higher-priority writer through a grant signal.

## Interface
- `sets_p`, no default, directory sets.
- `rows_per_set_p`, no default, RAM rows per set.
- `tag_sets_per_row_p`, no default, fixed at 2 (LCE bit 0 selects the tag set; LCE >> 1 is the row).
- `row_width_p`, no default, RAM row width = 2 * `assoc_p` * dir entry width.
- `num_lce_p`, no default, LCE count.
- `assoc_p`, no default, LCE associativity.
- `tag_width_p`, no default, directory tag width.
- `clk_i` in 1: clock.
- `reset_i` in 1: synchronous, active-high reset.
- `req_v_i` in 1: request valid.
- `req_ready_and_o` out 1: ready; a transfer occurs when both are high.
- `req_set_i` in lg(`sets_p`): set to walk.
- `req_lce_i` in lg(`num_lce_p`): requesting LCE.
- `req_lru_way_i` in lg(`assoc_p`): LRU way.
- `ram_v_o` out 1: read request.
- `ram_addr_o` out lg(`sets_p` * `rows_per_set_p`): address = set * `rows_per_set_p` + row.
- `ram_yumi_i` in 1: read granted this cycle.
- `ram_data_i` in `row_width_p`: read data, valid exactly 1 cycle after the grant.
- `row_v_o` out 1: streamed row valid (1-cycle pulse, no backpressure).
- `row_o` out `row_width_p`: row data.
- `row_num_o` out lg(`rows_per_set_p`): row index.
- `row_last_o` out 1: final row of the walk.
- `lru_v_o` out 1: LRU result valid, held until consumed.
- `lru_yumi_i` in 1: LRU result consumed.
- `lru_coh_state_o` out `bp_coh_states_e`: LRU way state.
- `lru_tag_o` out `tag_width_p`: LRU way tag.

## Operation
The FSM has three states: `e_ready`, `e_read` and `e_resp`.

- **`e_ready`**
  - `req_ready_and_o` = 1.
  - On handshake, latch set, LCE and way; clear the read counter (`rd_cnt`) and the return counter (`ret_cnt`); go to `e_read`.
- **`e_read`**
  - `ram_v_o` = 1 while `rd_cnt` < `rows_per_set_p`, with `ram_addr_o` computed from `rd_cnt`.
  - `rd_cnt` increments only on `ram_yumi_i`. A denied cycle holds the address and re-requests.
  - A one-bit `pending` register is set on grant. The cycle after a grant, the block drives `row_v_o`, `row_o` = `ram_data_i` and `row_num_o` = `ret_cnt`, then increments `ret_cnt`.
  - The returned row feeds `bp_cce_dir_lru_extract`:
    - `row_num_i` = `ret_cnt`.
    - `row_v_i[j]` = ((`ret_cnt` * 2 + j) < `num_lce_p`).
  - When the extract module's valid output is high, the block registers state and tag into the LRU holding registers.
  - `row_last_o` is asserted with the return where `ret_cnt` = `rows_per_set_p` - 1.
  - On that last return, go to `e_resp`.
- **`e_resp`**
  - `lru_v_o` = 1, holding the captured values.
  - On `lru_yumi_i`, go to `e_ready`.
  - If the requesting LCE's row was never valid, the result is the invalid state (`e_COH_I`) with tag 0. This happens only on a misconfiguration, and `lru_v_o` is still raised.
- **Width rules**
  - Counters are lg(`rows_per_set_p`) + 1 bits so they can count to `rows_per_set_p` without wrap-around.
  - The address is computed at full width with no truncation.
- **Boundaries**
  - With `rows_per_set_p` = 1, the single row is both first and last.
  - `ram_yumi_i` while `ram_v_o` = 0 is ignored.
  - `lru_yumi_i` outside `e_resp` is ignored.
  - A new request is not accepted in the same cycle as `lru_yumi_i`; it is accepted the following cycle.
- **Reset**
  - Reset forces `e_ready` from any state and clears the counters, `pending` and the LRU registers. An in-flight RAM return is discarded.
  - Reset values of all outputs are 0, except `req_ready_and_o`, which is 1 the cycle after reset deasserts and is 0 while `reset_i` = 1.

## Timing
- Request handshake to first `ram_v_o`: 1 cycle.
- With continuous grants:
  - Reads are back to back.
  - `row_v_o` follows each grant by exactly 1 cycle.
  - `lru_v_o` rises 1 cycle after `row_last_o`.
- Total request-to-`lru_v_o` latency = `rows_per_set_p` + 2 cycles, plus one cycle per denied grant.
- `lru_coh_state_o` and `lru_tag_o` are registered outputs.
- `row_o` is combinational from `ram_data_i`.

## Structure
- `bp_coh_states_e` and `declare_bp_cce_dir_entry_s` come from `bp_common_pkg` / `bp_me_defines.svh`.
- The FSM state enum is local to the module.
- Instantiate one `bp_cce_dir_lru_extract` sub-module.
- Counters use `bsg_counter_clear_up`.

## Test plan
Bench configuration: `sets_p` = 64, `rows_per_set_p` = 4, `num_lce_p` = 8, `assoc_p` = 8.

- **Full walk, no stalls:** request set 5, LCE 5, way 3, with `ram_yumi_i` tied to 1.
  - Required: addresses 20, 21, 22, 23 on consecutive cycles.
  - Required: `row_num_o` 0–3; `row_last_o` with row 3.
  - Required: `lru_v_o` at cycle 6, carrying the state/tag of row 2, tag set 1, way 3.
- **Grant stall:** deny `ram_yumi_i` for 3 cycles on the second read.
  - Required: `ram_addr_o` holds 21 throughout the stall.
  - Required: no `row_v_o` bubble other than the stall, and latency grows by 3.
- **Partial LCE population:** `num_lce_p` = 6 and LCE 5.
  - Required: `row_v_i` = 2'b11 for row 2 and `row_v_i` = 2'b00 for row 3.
  - Required: LRU taken from row 2.
- **Held result and back-to-back requests:** delay `lru_yumi_i` 5 cycles.
  - Required: `lru_v_o` and the data stay stable for those cycles.
  - Required: `req_ready_and_o` = 0 until the cycle after the yumi.
  - Then issue a second request to set 63 and check addresses 252–255.
- **Reset mid-walk:** assert `reset_i` after 2 grants.
  - Required: all outputs return to 0 and no `row_v_o` is produced from the discarded return.
  - Required: `req_ready_and_o` = 1 after reset.
- **Single-row set:** `rows_per_set_p` = 1.
  - Required: one read, with `row_last_o` on the first row and `lru_v_o` 3 cycles after the handshake.
